// File: rtl/pulse_period_checker.sv
// Pulse period checker: monitors a single-cycle pulse stream, measures the
// spacing between pulses, reports lock after a run of good intervals and
// flags early/late and missing pulses with a saturating error counter.
module pulse_period_checker #(
    parameter int unsigned PERIOD     = 10,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pulse_in,
    output logic             o_locked,
    output logic             o_period_err,
    output logic             o_missing_err,
    output logic [CNT_W-1:0] o_last_interval,
    output logic [7:0]       o_err_count
);

    localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_LO   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0]  CNT_HI   = CNT_W'(PERIOD + TOL);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StWaitFirst,
        StTrack,
        StLocked
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [GOOD_W-1:0]  r_good;
    logic               r_locked;
    logic               r_period_err;
    logic               r_missing_err;
    logic [CNT_W-1:0]   r_last_interval;
    logic [7:0]         r_err_count;

    state_e             w_state_d;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [GOOD_W-1:0]  w_good_d;
    logic               w_locked_d;
    logic               w_period_err_d;
    logic               w_missing_err_d;
    logic [CNT_W-1:0]   w_last_interval_d;
    logic [7:0]         w_err_count_d;

    logic               w_in_window;
    logic [GOOD_W-1:0]  w_good_inc;
    logic [7:0]         w_err_inc;

    // Window test and saturating increments used by the next-state logic.
    always_comb begin
        w_in_window = (r_cnt >= CNT_LO) && (r_cnt <= CNT_HI);
        w_good_inc  = (r_good == GOOD_MAX) ? r_good : r_good + GOOD_W'(1);
        w_err_inc   = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
    end

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        w_state_d         = r_state;
        w_cnt_d           = r_cnt;
        w_good_d          = r_good;
        w_locked_d        = r_locked;
        w_period_err_d    = 1'b0;
        w_missing_err_d   = 1'b0;
        w_last_interval_d = r_last_interval;
        w_err_count_d     = r_err_count;

        if (!i_start) begin
            // Disable drops lock and the reference; history is kept.
            w_state_d  = StIdle;
            w_locked_d = 1'b0;
            w_cnt_d    = '0;
            w_good_d   = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Pulse on the enabling edge is deliberately ignored.
                    w_state_d = StWaitFirst;
                end
                StWaitFirst: begin
                    if (i_pulse_in) begin
                        w_cnt_d   = CNT_W'(1);
                        w_state_d = StTrack;
                    end
                end
                StTrack, StLocked: begin
                    if (i_pulse_in) begin
                        w_last_interval_d = r_cnt;
                        w_cnt_d           = CNT_W'(1);
                        if (w_in_window) begin
                            w_good_d = w_good_inc;
                            if (w_good_inc == GOOD_MAX) begin
                                w_locked_d = 1'b1;
                                w_state_d  = StLocked;
                            end
                        end else begin
                            // Out-of-window pulse becomes the new reference.
                            w_period_err_d = 1'b1;
                            w_err_count_d  = w_err_inc;
                            w_good_d       = '0;
                            w_locked_d     = 1'b0;
                            w_state_d      = StTrack;
                        end
                    end else if (r_cnt == CNT_HI) begin
                        w_missing_err_d = 1'b1;
                        w_err_count_d   = w_err_inc;
                        w_good_d        = '0;
                        w_locked_d      = 1'b0;
                        w_cnt_d         = '0;
                        w_state_d       = StWaitFirst;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_good          <= '0;
            r_locked        <= 1'b0;
            r_period_err    <= 1'b0;
            r_missing_err   <= 1'b0;
            r_last_interval <= '0;
            r_err_count     <= '0;
        end else begin
            r_state         <= w_state_d;
            r_cnt           <= w_cnt_d;
            r_good          <= w_good_d;
            r_locked        <= w_locked_d;
            r_period_err    <= w_period_err_d;
            r_missing_err   <= w_missing_err_d;
            r_last_interval <= w_last_interval_d;
            r_err_count     <= w_err_count_d;
        end
    end

    assign o_locked        = r_locked;
    assign o_period_err    = r_period_err;
    assign o_missing_err   = r_missing_err;
    assign o_last_interval = r_last_interval;
    assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Bench for pulse_period_checker: a TOL=0 and a TOL=1 instance share one
// stimulus stream; both are compared every cycle to a timestamp-based model,
// plus a table of hand-derived vectors and directed tolerance/saturation checks.
module tb_pulse_period_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pulse = 1'b0;

    logic       lk0, pe0, me0, lk1, pe1, me1;
    logic [7:0] li0, ec0, li1, ec1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulse_period_checker #(.PERIOD(10), .TOL(0), .LOCK_COUNT(3), .CNT_W(8)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pulse_in(pulse),
        .o_locked(lk0), .o_period_err(pe0), .o_missing_err(me0),
        .o_last_interval(li0), .o_err_count(ec0)
    );

    pulse_period_checker #(.PERIOD(10), .TOL(1), .LOCK_COUNT(3), .CNT_W(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pulse_in(pulse),
        .o_locked(lk1), .o_period_err(pe1), .o_missing_err(me1),
        .o_last_interval(li1), .o_err_count(ec1)
    );

    // Reference model: remembers the edge number of the reference pulse and
    // measures intervals as timestamp differences.
    int cyc = 0;
    int m_per[2] = '{10, 10};
    int m_tol[2] = '{0, 1};
    bit m_en[2], m_ref_ok[2], m_lk[2], m_pe[2], m_me[2];
    int m_ref[2], m_good[2], m_last[2], m_err[2];

    task automatic m_step(input logic r, input logic s, input logic p);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_pe[i] = 0;
            m_me[i] = 0;
            if (r) begin
                m_en[i] = 0; m_ref_ok[i] = 0; m_good[i] = 0; m_lk[i] = 0;
                m_last[i] = 0; m_err[i] = 0;
            end else if (!s) begin
                m_en[i] = 0; m_ref_ok[i] = 0; m_good[i] = 0; m_lk[i] = 0;
            end else if (!m_en[i]) begin
                m_en[i] = 1;
                m_ref_ok[i] = 0;
            end else if (p) begin
                if (!m_ref_ok[i]) begin
                    m_ref_ok[i] = 1;
                    m_ref[i] = cyc;
                end else begin
                    int n;
                    n = cyc - m_ref[i];
                    m_last[i] = n;
                    m_ref[i] = cyc;
                    if (n >= m_per[i] - m_tol[i] && n <= m_per[i] + m_tol[i]) begin
                        if (m_good[i] < 3) m_good[i]++;
                        if (m_good[i] == 3) m_lk[i] = 1;
                    end else begin
                        m_pe[i] = 1;
                        if (m_err[i] < 255) m_err[i]++;
                        m_good[i] = 0;
                        m_lk[i] = 0;
                    end
                end
            end else if (m_ref_ok[i] && (cyc - m_ref[i]) == m_per[i] + m_tol[i]) begin
                m_me[i] = 1;
                if (m_err[i] < 255) m_err[i]++;
                m_good[i] = 0;
                m_lk[i] = 0;
                m_ref_ok[i] = 0;
            end
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [18:0] a0, a1, e0, e1;
        a0 = {lk0, pe0, me0, li0, ec0};
        a1 = {lk1, pe1, me1, li1, ec1};
        e0 = {m_lk[0], m_pe[0], m_me[0], 8'(m_last[0]), 8'(m_err[0])};
        e1 = {m_lk[1], m_pe[1], m_me[1], 8'(m_last[1]), 8'(m_err[1])};
        n_vec += 2;
        if (a0 !== e0) begin
            n_bad++;
            $display("FAIL model_tol0 @edge %0d: got lk/pe/me/last/err=%b, expected %b",
                     cyc, a0, e0);
        end
        if (a1 !== e1) begin
            n_bad++;
            $display("FAIL model_tol1 @edge %0d: got lk/pe/me/last/err=%b, expected %b",
                     cyc, a1, e1);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic r, input logic s, input logic p);
        rst = r; start = s; pulse = p;
        @(posedge clk);
        #1;
        m_step(r, s, p);
        cmp_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic rst, start, pulse;
        int   gap;
        logic lk, pe, me;
        int   last, err;
    } vec_t;

    vec_t tbl[28];

    initial begin
        // gap = quiet cycles (same start, no pulse) before the vector edge;
        // expected fields are the TOL=0 instance outputs after that edge.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};   // reset
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};   // enable, pulse ignored
        tbl[2]  = '{0, 1, 1, 2, 0, 0, 0, 0, 0};   // first reference pulse
        tbl[3]  = '{0, 1, 1, 9, 0, 0, 0, 10, 0};
        tbl[4]  = '{0, 1, 1, 9, 0, 0, 0, 10, 0};
        tbl[5]  = '{0, 1, 1, 9, 1, 0, 0, 10, 0};  // locked after 3rd interval
        tbl[6]  = '{0, 1, 1, 6, 0, 1, 0, 7, 1};   // early pulse
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 7, 1};   // strobe one cycle only
        tbl[8]  = '{0, 1, 1, 8, 0, 0, 0, 10, 1};
        tbl[9]  = '{0, 1, 1, 9, 0, 0, 0, 10, 1};
        tbl[10] = '{0, 1, 1, 9, 1, 0, 0, 10, 1};  // relock
        tbl[11] = '{0, 1, 0, 9, 0, 0, 1, 10, 2};  // missing pulse
        tbl[12] = '{0, 1, 1, 4, 0, 0, 0, 10, 2};  // new reference, no error
        tbl[13] = '{0, 1, 1, 9, 0, 0, 0, 10, 2};
        tbl[14] = '{0, 1, 1, 9, 0, 0, 0, 10, 2};
        tbl[15] = '{0, 1, 1, 9, 1, 0, 0, 10, 2};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 10, 2};  // drop start: unlock, hold
        tbl[17] = '{0, 0, 1, 5, 0, 0, 0, 10, 2};  // pulses ignored
        tbl[18] = '{0, 1, 1, 0, 0, 0, 0, 10, 2};  // re-enable, pulse ignored
        tbl[19] = '{0, 1, 1, 3, 0, 0, 0, 10, 2};  // reference
        tbl[20] = '{0, 1, 1, 9, 0, 0, 0, 10, 2};
        tbl[21] = '{0, 1, 1, 9, 0, 0, 0, 10, 2};
        tbl[22] = '{0, 1, 1, 9, 1, 0, 0, 10, 2};
        tbl[23] = '{0, 1, 1, 9, 1, 0, 0, 10, 2};  // reference for held-high
        tbl[24] = '{0, 1, 1, 0, 0, 1, 0, 1, 3};   // second high cycle
        tbl[25] = '{0, 1, 1, 0, 0, 1, 0, 1, 4};   // third high cycle
        tbl[26] = '{0, 1, 0, 0, 0, 0, 0, 1, 4};
        tbl[27] = '{1, 1, 1, 3, 0, 0, 0, 0, 0};   // reset with pulse

        @(posedge clk);
        #1;

        for (int v = 0; v < 28; v++) begin
            for (int k = 0; k < tbl[v].gap; k++) step(1'b0, tbl[v].start, 1'b0);
            step(tbl[v].rst, tbl[v].start, tbl[v].pulse);
            cmp_int($sformatf("tbl%0d_locked", v), int'(lk0), int'(tbl[v].lk));
            cmp_int($sformatf("tbl%0d_period_err", v), int'(pe0), int'(tbl[v].pe));
            cmp_int($sformatf("tbl%0d_missing_err", v), int'(me0), int'(tbl[v].me));
            cmp_int($sformatf("tbl%0d_last", v), int'(li0), tbl[v].last);
            cmp_int($sformatf("tbl%0d_err", v), int'(ec0), tbl[v].err);
        end

        // Tolerance instance: intervals 9, 11, 10 lock; miss at 11; accept 11.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(8);  step(1'b0, 1'b1, 1'b1);
        cmp_int("tol_int9_last", int'(li1), 9);
        cmp_int("tol_int9_perr", int'(pe1), 0);
        idle(10); step(1'b0, 1'b1, 1'b1);
        cmp_int("tol_int11_last", int'(li1), 11);
        cmp_int("tol_int11_perr", int'(pe1), 0);
        idle(9);  step(1'b0, 1'b1, 1'b1);
        cmp_int("tol_lock", int'(lk1), 1);
        idle(10);
        cmp_int("tol_no_miss_at10", int'(me1), 0);
        step(1'b0, 1'b1, 1'b0);
        cmp_int("tol_miss_at11", int'(me1), 1);
        cmp_int("tol_miss_unlock", int'(lk1), 0);
        cmp_int("tol_miss_err", int'(ec1), 1);
        step(1'b0, 1'b1, 1'b1);
        idle(10); step(1'b0, 1'b1, 1'b1);
        cmp_int("tol_accept11_perr", int'(pe1), 0);
        cmp_int("tol_accept11_last", int'(li1), 11);
        cmp_int("tol_accept11_err", int'(ec1), 1);

        // Saturation: pulse held high produces an error every cycle.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 1'b1);
        cmp_int("sat_err0", int'(ec0), 255);
        cmp_int("sat_err1", int'(ec1), 255);
        step(1'b0, 1'b1, 1'b1);
        cmp_int("sat_hold0", int'(ec0), 255);

        // Randomized near-periodic stream with jitter, drops, bursts, enable and
        // reset activity, checked against the model each cycle.
        begin
            int   cd;
            logic s, r, p;
            cd = 0;
            s  = 1'b1;
            step(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 4000; k++) begin
                r = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 199) == 0) s = ~s;
                p = 1'b0;
                if (cd == 0) begin
                    p  = ($urandom_range(0, 19) != 0);
                    cd = 7 + $urandom_range(0, 4);
                end else begin
                    cd--;
                    if ($urandom_range(0, 149) == 0) p = 1'b1;
                end
                step(r, s, p);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_period_checker.md
Name: pulse_period_checker

Overview:
- Receive-side counterpart of the periodic pulse generator: consumes a single-cycle pulse stream such as op_sig and checks that pulses arrive every PERIOD clocks.
- Reports lock after LOCK_COUNT consecutive correct intervals, flags early/late (period) and missing pulses, and keeps a saturating error count.
- Sits beside the generator in the same clock domain as a self-checking monitor and lock indicator.

Parameters:
- PERIOD, 10, expected pulse spacing in clock cycles.
- TOL, 0, allowed deviation (+/-) in cycles. Constraint: PERIOD-TOL >= 2.
- LOCK_COUNT, 3, consecutive good intervals required to assert locked (>= 1).
- CNT_W, 8, interval counter width. Constraint: PERIOD+TOL <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  enable: checking runs while high.
- pulse_in  in  1  pulse under test; each high sample counts as one pulse event.
- locked  out  1  level: LOCK_COUNT consecutive good intervals seen since the last error or resync.
- period_err  out  1  one-cycle strobe: pulse arrived outside [PERIOD-TOL, PERIOD+TOL].
- missing_err  out  1  one-cycle strobe: no pulse by PERIOD+TOL cycles.
- last_interval  out  CNT_W  most recent measured interval.
- err_count  out  8  total period_err + missing_err events; saturates at 255.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; cnt=0, good=0; locked=0, period_err=0, missing_err=0, last_interval=0, err_count=0. rst overrides all other inputs.
- Priority at each edge: rst > start=0 > pulse_in > missing check.
- All outputs are registered. An event sampled at edge k is visible after edge k.
- Strobes default to 0 every cycle.
- States:
  - IDLE: wait for start=1, then go to WAIT_FIRST. The pulse_in sample on that same edge is ignored.
  - WAIT_FIRST: on pulse_in=1, set cnt<=1 and go to TRACK. No checks and no errors in this state.
  - TRACK and LOCKED: on each edge without a pulse, cnt<=cnt+1.
    - If there is no pulse and cnt==PERIOD+TOL: missing_err=1, err_count+1, good=0, locked=0, go to WAIT_FIRST.
  - Pulse in TRACK or LOCKED: last_interval<=cnt, cnt<=1.
    - If PERIOD-TOL <= cnt <= PERIOD+TOL: good<=good+1 (saturates at LOCK_COUNT). When the new good==LOCK_COUNT, locked<=1 and state=LOCKED.
    - Otherwise: period_err=1, err_count+1, good=0, locked=0, state=TRACK. That pulse becomes the new reference.
- Interval definition: a pulse at edge t followed by the next pulse at edge t+N measures N. A generator pulsing every 10 clocks measures 10.
- A pulse on the same edge that cnt reaches the limit is checked as a pulse, not reported as missing.
- Multi-cycle-high pulse_in: each high cycle is an event, so the second high cycle measures interval 1 and raises period_err.
- start=0 in any non-IDLE state: next edge goes to IDLE; locked=0, cnt=0, good=0.
  - last_interval and err_count are held; only rst clears them.
  - Re-enabling requires a new first pulse.
- err_count saturates at 255; it does not wrap.

Test Plan:
- Lock-up: rst for 1 cycle, start=1, pulse every 10 clocks (first at edge t0) -> no errors; last_interval=10 after t0+10; locked=1 after edge t0+30 (LOCK_COUNT=3); err_count=0.
- Early pulse: after lock, pulse 7 clocks after the previous one -> period_err high exactly 1 cycle, locked=0, last_interval=7, err_count=1. Pulses then resume every 10 from the early one -> locked=1 again after the third good interval.
- Missing pulse: after lock, suppress the next pulse -> missing_err 1 cycle after the edge where cnt=10 (10 clocks after the last pulse), locked=0, err_count+1. The next pulse produces no error, and lock returns after 3 further good intervals.
- Tolerance (TOL=1 instance): intervals 9, 11, 10 -> all good, locked=1. Then no pulse for 11 clocks -> missing_err at cnt=11. A pulse arriving exactly at cnt=11 is accepted with no error.
- Enable/reset mid-operation: while locked, drop start -> locked=0 next cycle, err_count and last_interval held, pulses ignored. Raise start again -> relock after 1 reference pulse plus 3 good intervals. Assert rst together with a pulse -> all outputs 0, no strobe.
- Stream/saturation: pulse_in held high 3 cycles after a reference pulse -> 2 period_err events. Force more than 255 errors -> err_count holds at 255.
